// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_pkg;

    localparam int SPI_BYTE_W   = 8;
    localparam int SPI_BITCNT_W = 3;
    localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_TX = 8'hFF;

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } spi_state_e;

    typedef struct packed {
        logic                  first;
        logic [SPI_BYTE_W-1:0] data;
    } spi_rx_entry_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Show-ahead synchronous FIFO of RX entries; push and pop in one cycle are both
// honoured even when full.
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  spi_rx_entry_t din_i,
    input  logic          pop_i,
    output spi_rx_entry_t dout_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    spi_rx_entry_t mem_q [FIFO_DEPTH];
    logic          wr_en, rd_en;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || pop_i);
    // Head reads as zero while empty so the outputs have a defined reset value.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled SCK/CSX/SDI, MSB-first RX into a FIFO, TX reply shifter.
// Optional macro SPI_TARGET_DCX_EN adds a DCX input that tags command bytes.
module spi_target
    import spi_pkg::*;
#(
    parameter int                    SYNC_STAGES = 2,
    parameter int                    FIFO_DEPTH  = 4,
    parameter logic [SPI_BYTE_W-1:0] IDLE_TX     = SPI_IDLE_TX
) (
    input  logic                  CLK_100MHz,
    input  logic                  reset_n,
    input  logic                  SCK,
    input  logic                  CSX,
    input  logic                  SDI,
`ifdef SPI_TARGET_DCX_EN
    input  logic                  DCX,
`endif
    output logic                  SDO,
    output logic                  SDO_OE,
    output logic [SPI_BYTE_W-1:0] rx_data,
    output logic                  rx_first,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [SPI_BYTE_W-1:0] tx_data,
    input  logic                  tx_load,
    output logic                  tx_ready,
    output logic                  frame_active,
    output logic                  frame_abort,
    output logic                  overrun,
    input  logic                  overrun_clr
);

`ifdef SPI_TARGET_DCX_EN
    localparam int NSIG = 4;
`else
    localparam int NSIG = 3;
`endif

    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge CLK_100MHz or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // Bit order: {DCX,} SDI, CSX, SCK. Chains reset to 0 so a CSX already low
    // at reset release never looks like a falling edge.
    logic [NSIG-1:0]                  pins;
    logic [SYNC_STAGES-1:0][NSIG-1:0] sync_q;
    logic [NSIG-1:0]                  sync_s, hist_q;

`ifdef SPI_TARGET_DCX_EN
    assign pins = {DCX, SDI, CSX, SCK};
`else
    assign pins = {SDI, CSX, SCK};
`endif
    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
            hist_q <= sync_s;
        end
    end

    logic sck_rise, sck_fall, csx_rise, csx_fall, sdi_s;
    assign sck_rise = sync_s[0] & ~hist_q[0];
    assign sck_fall = ~sync_s[0] & hist_q[0];
    assign csx_rise = sync_s[1] & ~hist_q[1];
    assign csx_fall = ~sync_s[1] & hist_q[1];
    // Data comes from the history stage; it is stable around the SCK edge anyway.
    assign sdi_s    = hist_q[2];

    spi_state_e              state_q, state_d;
    logic [SPI_BYTE_W-2:0]   shift_rx_q, shift_rx_d;
    logic [SPI_BYTE_W-1:0]   shift_tx_q, shift_tx_d;
    logic [SPI_BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-1:0]   hold_q, hold_d, next_tx;
    logic                    hold_full_q, hold_full_d;
    logic                    push_q, push_d;
    spi_rx_entry_t           entry_q, entry_d;
    logic                    abort_q, abort_d;
    logic                    overrun_q, overrun_d;
`ifndef SPI_TARGET_DCX_EN
    logic                    first_q, first_d;
`endif

    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shift_rx_q  <= '0;
            shift_tx_q  <= IDLE_TX;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            push_q      <= 1'b0;
            entry_q     <= '0;
            abort_q     <= 1'b0;
            overrun_q   <= 1'b0;
`ifndef SPI_TARGET_DCX_EN
            first_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            shift_rx_q  <= shift_rx_d;
            shift_tx_q  <= shift_tx_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            push_q      <= push_d;
            entry_q     <= entry_d;
            abort_q     <= abort_d;
            overrun_q   <= overrun_d;
`ifndef SPI_TARGET_DCX_EN
            first_q     <= first_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_rx_d  = shift_rx_q;
        shift_tx_d  = shift_tx_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        push_d      = 1'b0;
        entry_d     = entry_q;
        abort_d     = 1'b0;
`ifndef SPI_TARGET_DCX_EN
        first_d     = first_q;
`endif
        next_tx     = hold_full_q ? hold_q : IDLE_TX;

        if (tx_load && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (csx_fall) begin
                    state_d    = ST_ACTIVE;
                    shift_tx_d = next_tx;
                    bit_cnt_d  = '0;
                    if (hold_full_q) hold_full_d = 1'b0;
`ifndef SPI_TARGET_DCX_EN
                    first_d    = 1'b1;
`endif
                end
            end
            ST_ACTIVE: begin
                // CSX rise wins over any SCK edge seen in the same cycle.
                if (csx_rise) begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    if (bit_cnt_q != '0) abort_d = 1'b1;
                end else if (sck_rise) begin
                    shift_rx_d = {shift_rx_q[SPI_BYTE_W-3:0], sdi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        push_d       = 1'b1;
                        entry_d.data = {shift_rx_q, sdi_s};
`ifdef SPI_TARGET_DCX_EN
                        entry_d.first = ~hist_q[3];
`else
                        entry_d.first = first_q;
                        first_d       = 1'b0;
`endif
                    end
                end else if (sck_fall) begin
                    if (bit_cnt_q != '0) begin
                        shift_tx_d = {shift_tx_q[SPI_BYTE_W-2:0], 1'b0};
                    end else begin
                        shift_tx_d = next_tx;
                        if (hold_full_q) hold_full_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    spi_rx_entry_t head;
    logic          fifo_full, fifo_empty;

    spi_rx_fifo #(
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (CLK_100MHz),
        .rst_ni (rst_n),
        .push_i (push_q),
        .din_i  (entry_q),
        .pop_i  (rx_ready),
        .dout_o (head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // A new drop beats a simultaneous clear.
    always_comb begin
        overrun_d = overrun_q & ~overrun_clr;
        if (push_q && fifo_full && !rx_ready) overrun_d = 1'b1;
    end

    assign SDO          = (state_q == ST_ACTIVE) ? shift_tx_q[SPI_BYTE_W-1] : 1'b1;
    assign SDO_OE       = (state_q == ST_ACTIVE);
    assign frame_active = (state_q == ST_ACTIVE);
    assign rx_data      = head.data;
    assign rx_first     = head.first;
    assign rx_valid     = ~fifo_empty;
    assign tx_ready     = ~hold_full_q;
    assign frame_abort  = abort_q;
    assign overrun      = overrun_q;

endmodule
